// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
package mips_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int          DIV_ITERS     = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_divider_if.sv
// Request/result bundle between the execute-stage HI/LO control and the divider.
// Requests are accepted only while busy is low; results are held until the next accepted start.
interface mips_divider_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/cla_32_bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
// Purely combinational; there is no handshake.
module cla_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;

  always_comb begin
    logic       cg;
    logic [3:0] gg;
    logic [3:0] pp;
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    cg = cin;
    for (int k = 0; k < 8; k++) begin
      gg = g[4*k +: 4];
      pp = p[4*k +: 4];
      c[4*k +: 4] = {
        gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & cg),
        gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cg),
        gg[0] | (pp[0] & cg),
        cg
      };
      cg = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
         | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & cg);
    end
    sum  = p ^ c;
    cout = cg;
  end

endmodule

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate: y = neg ? -a : a.
// Combinational; no handshake.
module div_abs_neg (
  input  logic [31:0] a,
  input  logic        neg,
  output logic [31:0] y
);

  assign y = neg ? (~a + 32'd1) : a;

endmodule

// File: rtl/mips_divider.sv
// Restoring DIV/DIVU, one quotient bit per clock; done pulses 34 cycles after the start cycle.
// start is ignored while busy; results hold until the next FIX edge.
module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mips_divider_if.slave  bus
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  div_state_t       state_q;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] dvd_q;
  logic             qneg_q, rneg_q, dbz_q;
  logic             busy_q, done_q, dbz_flag_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] d_inv, diff;
  logic             trial_cout, ok;

  div_abs_neg u_abs_dvd (
    .a   (bus.dividend),
    .neg (bus.is_signed & bus.dividend[31]),
    .y   (dvd_mag)
  );

  div_abs_neg u_abs_dvs (
    .a   (bus.divisor),
    .neg (bus.is_signed & bus.divisor[31]),
    .y   (dvs_mag)
  );

  div_abs_neg u_fix_q (
    .a   (q_q),
    .neg (qneg_q),
    .y   (quot_fix)
  );

  div_abs_neg u_fix_r (
    .a   (r_q),
    .neg (rneg_q),
    .y   (rem_fix)
  );

  assign d_inv = ~d_q;

  cla_32_bit u_trial (
    .a    (rs[WIDTH-1:0]),
    .b    (d_inv),
    .cin  (1'b1),
    .sum  (diff),
    .cout (trial_cout)
  );

  // The partial remainder is always below the divisor after a step, so its
  // 33rd bit is zero and only the low WIDTH bits need storing.
  always_comb begin
    rs  = {r_q, q_q[WIDTH-1]};
    ok  = rs[WIDTH] | trial_cout;
    r_d = ok ? diff : rs[WIDTH-1:0];
    q_d = {q_q[WIDTH-2:0], ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      d_q        <= '0;
      dvd_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_flag_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            q_q     <= dvd_mag;
            d_q     <= dvs_mag;
            r_q     <= '0;
            dvd_q   <= bus.dividend;
            qneg_q  <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
            rneg_q  <= bus.is_signed & bus.dividend[31];
            dbz_q   <= (bus.divisor == '0);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
          if (dbz_q) begin
            quot_q     <= DIV_BY_ZERO_Q;
            rem_q      <= dvd_q;
            dbz_flag_q <= 1'b1;
          end else begin
            quot_q     <= quot_fix;
            rem_q      <= rem_fix;
            dbz_flag_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_flag_q;

endmodule

// File: tb/tb_mips_divider.sv
// Randomised and directed checks of mips_divider against an arithmetic reference model.
module tb_mips_divider;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mips_divider_if bus ();

  mips_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // DIV truncates toward zero with the remainder taking the dividend's sign;
  // 64-bit arithmetic keeps 0x80000000 / -1 well defined.
  task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
  endtask

  // Called right after issue() in cycle 0; samples cycles 1..34 (and 35 unless chaining).
  task automatic finish_op(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit junk, input bit chain,
                           input logic csgn, input logic [31:0] ca, input logic [31:0] cb);
    logic [31:0] eq, er;
    logic        ez;
    logic [31:0] gq, gr;
    logic        gz;
    int          done_at, done_n, busy_n;
    model(sgn, a, b, eq, er, ez);
    done_at = 0;
    done_n  = 0;
    busy_n  = 0;
    gq = '0;
    gr = '0;
    gz = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at == 0) done_at = k;
      end
      if (k == 34) begin
        gq = bus.quotient;
        gr = bus.remainder;
        gz = bus.div_by_zero;
      end
      if (k == 34 && chain) begin
        issue(csgn, ca, cb);
      end else if (junk && (k == 5 || k == 20)) begin
        issue(~sgn, $urandom, $urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    chk({tag, "_lat"},  done_at, 34);
    chk({tag, "_busy"}, busy_n,  33);
    chk({tag, "_q"},    gq, eq);
    chk({tag, "_r"},    gr, er);
    chk({tag, "_dbz"},  32'(gz), 32'(ez));
    if (!chain) begin
      @(negedge clk);
      if (bus.done) done_n++;
      chk({tag, "_pulse"}, done_n, 1);
      chk({tag, "_hold"},  bus.quotient, eq);
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input bit junk);
    @(negedge clk);
    issue(sgn, a, b);
    finish_op(tag, sgn, a, b, junk, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    int          done_n;
    n_cmp = 0;
    n_err = 0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_q",    bus.quotient, 0);
    chk("rst_r",    bus.remainder, 0);
    chk("rst_dbz",  32'(bus.div_by_zero), 0);
    rst = 1'b0;

    run("divu_100_7",  1'b0, 32'd100, 32'd7, 1'b0);
    run("div_m100_7",  1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
    run("div_100_m7",  1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);
    run("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run("divu_ovf",    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run("div_5_0",     1'b1, 32'd5, 32'd0, 1'b0);
    run("divu_5_0",    1'b0, 32'd5, 32'd0, 1'b0);
    run("junk_starts", 1'b0, 32'd100, 32'd7, 1'b1);

    @(negedge clk);
    issue(1'b0, 32'd100, 32'd7);
    finish_op("chain_a", 1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 32'd9, 32'd2);
    finish_op("chain_b", 1'b0, 32'd9, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset in the middle of a run must clear everything and suppress done.
    @(negedge clk);
    issue(1'b1, 32'd12345, 32'd17);
    repeat (15) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_q",    bus.quotient, 0);
    chk("mid_rst_r",    bus.remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    chk("mid_rst_nodone", done_n, 0);
    run("post_rst", 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(1, 0));
      a   = $urandom;
      case ($urandom_range(4, 0))
        0:       b = $urandom;
        1:       b = $urandom_range(15, 1);
        2:       b = 32'd0 - $urandom_range(15, 1);
        3:       b = 32'd0;
        default: b = $urandom >> $urandom_range(31, 0);
      endcase
      if (i % 7 == 3) a = 32'h8000_0000;
      run($sformatf("rnd%0d", i), sgn, a, b, 1'(i % 5 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
